// File: rtl/i1_phase_sequencer_if.sv
// Command channel of the i1 phase sequencer: one command is accepted per valid/ready handshake.
interface i1_phase_sequencer_if #(
    parameter int DWELL_W = 4
) ();
    logic               cmd_valid;
    logic               cmd_ready;
    logic [6:0]         cmd_v7;
    logic [1:0]         cmd_sel;
    logic               cmd_en;
    logic [DWELL_W-1:0] cmd_hold;

    modport master (
        output cmd_valid, cmd_v7, cmd_sel, cmd_en, cmd_hold,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_v7, cmd_sel, cmd_en, cmd_hold,
        output cmd_ready
    );
endinterface

// File: rtl/i1_phase_sequencer.sv
// Front end of the i1 decode stage: latches one command, then walks the one-hot
// V22 phase vector with a programmable dwell per phase, holding all i1 inputs stable.
module i1_phase_sequencer #(
    parameter int DWELL_W = 4,
    parameter int NPHASE  = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    i1_phase_sequencer_if.slave  cmd,
    input  logic                 abort,
    output logic [6:0]           v7_out,
    output logic                 v8_out,
    output logic                 v9_out,
    output logic                 v29_out,
    output logic [NPHASE-1:0]    v22_out,
    output logic                 busy,
    output logic                 done
);
    localparam int PH_W = $clog2(NPHASE);
    localparam logic [PH_W-1:0] LAST_PHASE = PH_W'(NPHASE - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [PH_W-1:0]    phase_q;
    logic [DWELL_W-1:0] dwell_q;
    logic [DWELL_W-1:0] hold_q;
    logic               en_q;
    logic               accept;
    logic               step;

    // NOTE: every signal written here gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        step    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (cmd.cmd_valid) begin
                    accept  = 1'b1;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (dwell_q == '0) begin
                    if (phase_q == LAST_PHASE) state_d = S_DONE;
                    else                       step    = 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= '0;
            dwell_q <= '0;
            hold_q  <= '0;
            en_q    <= 1'b0;
            v7_out  <= '0;
            v8_out  <= 1'b0;
            v9_out  <= 1'b0;
        end else if (accept) begin
            phase_q <= '0;
            dwell_q <= cmd.cmd_hold;
            hold_q  <= cmd.cmd_hold;
            en_q    <= cmd.cmd_en;
            v7_out  <= cmd.cmd_v7;
            v8_out  <= cmd.cmd_sel[0];
            v9_out  <= cmd.cmd_sel[1];
        end else if (state_q == S_RUN && !abort) begin
            if (dwell_q != '0) begin
                dwell_q <= dwell_q - DWELL_W'(1);
            end else if (step) begin
                phase_q <= phase_q + PH_W'(1);
                dwell_q <= hold_q;
            end
        end
    end

    // Status outputs decode straight from state, so an async reset clears them at once.
    always_comb begin
        v22_out = '0;
        if (state_q == S_RUN) v22_out[phase_q] = 1'b1;
    end

    assign cmd.cmd_ready = (state_q == S_IDLE);
    assign busy          = (state_q == S_RUN) || (state_q == S_DONE);
    assign done          = (state_q == S_DONE);
    assign v29_out       = (state_q == S_RUN) && en_q;
endmodule

// File: tb/tb_i1_phase_sequencer.sv
// Scoreboard bench for i1_phase_sequencer: a predictor expands each accepted command
// into its expected per-cycle output trace; a monitor pops and compares every cycle.
module tb_i1_phase_sequencer;
    localparam int DWELL_W = 4;

    typedef struct packed {
        logic       ready;
        logic       busy;
        logic       done;
        logic       v29;
        logic [3:0] v22;
        logic [6:0] v7;
        logic       v8;
        logic       v9;
    } obs_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       abort = 1'b0;
    logic [6:0] v7_out;
    logic       v8_out, v9_out, v29_out, busy, done;
    logic [3:0] v22_out;

    i1_phase_sequencer_if #(.DWELL_W(DWELL_W)) bus ();

    i1_phase_sequencer #(.DWELL_W(DWELL_W), .NPHASE(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .cmd     (bus.slave),
        .abort   (abort),
        .v7_out  (v7_out),
        .v8_out  (v8_out),
        .v9_out  (v9_out),
        .v29_out (v29_out),
        .v22_out (v22_out),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cycle    = 0;
    int dut_done_cnt = 0;
    int exp_done_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cycle, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    obs_t       plan[$];
    obs_t       exp_q[$];
    obs_t       cur;
    obs_t       nxt;
    logic [6:0] last_v7;
    logic [1:0] last_sel;

    function automatic obs_t idle_obs(input logic [6:0] v7, input logic [1:0] sel);
        obs_t o;
        o       = '0;
        o.ready = 1'b1;
        o.v7    = v7;
        o.v8    = sel[0];
        o.v9    = sel[1];
        return o;
    endfunction

    // A command of hold h occupies 4*(h+1) RUN cycles (phase = k/(h+1)) then one DONE cycle.
    task automatic build_plan(input logic [6:0] v7, input logic [1:0] sel, input logic en,
                              input int h);
        obs_t o;
        for (int k = 0; k < 4 * (h + 1); k++) begin
            o      = idle_obs(v7, sel);
            o.ready = 1'b0;
            o.busy = 1'b1;
            o.v29  = en;
            o.v22  = 4'b0001 << (k / (h + 1));
            plan.push_back(o);
        end
        o       = idle_obs(v7, sel);
        o.ready = 1'b0;
        o.busy  = 1'b1;
        o.done  = 1'b1;
        plan.push_back(o);
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            plan.delete();
            exp_q.delete();
            last_v7  = '0;
            last_sel = '0;
            cur      = idle_obs('0, '0);
        end else begin
            if (cur.ready && bus.cmd_valid) begin
                last_v7  = bus.cmd_v7;
                last_sel = bus.cmd_sel;
                build_plan(bus.cmd_v7, bus.cmd_sel, bus.cmd_en, int'(bus.cmd_hold));
            end else if (cur.busy && !cur.done && abort) begin
                plan.delete();
            end
            nxt = (plan.size() > 0) ? plan.pop_front() : idle_obs(last_v7, last_sel);
            exp_q.push_back(nxt);
            cur = nxt;
        end
    end

    // ---------------- monitor ----------------
    obs_t e;
    obs_t a;
    always @(negedge clk) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : cur;
        a = {bus.cmd_ready, busy, done, v29_out, v22_out, v7_out, v8_out, v9_out};
        check("outputs", 32'(a), 32'(e));
        check("v22_onehot", 32'($countones(v22_out) <= 1), 32'(1));
        if (e.done) exp_done_cnt++;
        if (done)   dut_done_cnt++;
        cycle++;
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [6:0] v7, input logic [1:0] sel, input logic en,
                        input logic [DWELL_W-1:0] hold);
        bus.cmd_valid = 1'b1;
        bus.cmd_v7    = v7;
        bus.cmd_sel   = sel;
        bus.cmd_en    = en;
        bus.cmd_hold  = hold;
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic scramble_payload();
        bus.cmd_v7   = 7'($urandom);
        bus.cmd_sel  = 2'($urandom);
        bus.cmd_en   = 1'($urandom);
        bus.cmd_hold = DWELL_W'($urandom);
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_v7    = '0;
        bus.cmd_sel   = '0;
        bus.cmd_en    = 1'b0;
        bus.cmd_hold  = '0;
        #1;
        check("rst_ready", 32'(bus.cmd_ready), 32'(1));
        check("rst_busy",  32'(busy), 32'(0));
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (2) tick();

        // hold=0, en=1: four single-cycle phases, then DONE, then IDLE
        send(7'h00, 2'b00, 1'b1, 4'd0);
        repeat (7) tick();

        // hold=3, v7=0x55, payload changes during RUN must be ignored
        send(7'h55, 2'b10, 1'b1, 4'd3);
        for (int i = 0; i < 18; i++) begin
            scramble_payload();
            tick();
        end

        // abort on the 2nd cycle of phase index 2 (hold=1)
        send(7'h2a, 2'b01, 1'b1, 4'd1);
        repeat (5) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        repeat (3) tick();

        // abort together with valid in IDLE: still accepted
        abort = 1'b1;
        send(7'h11, 2'b11, 1'b0, 4'd0);
        abort = 1'b0;
        repeat (7) tick();

        // cmd_valid held high with changing payloads
        bus.cmd_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            scramble_payload();
            bus.cmd_hold = DWELL_W'($urandom_range(0, 2));
            tick();
        end
        bus.cmd_valid = 1'b0;
        repeat (14) tick();

        // async reset mid-run
        send(7'h7f, 2'b11, 1'b1, 4'd2);
        repeat (7) tick();
        rst_n = 1'b0;
        #1;
        check("arst_v22",   32'(v22_out), 32'(0));
        check("arst_busy",  32'(busy), 32'(0));
        check("arst_done",  32'(done), 32'(0));
        check("arst_v29",   32'(v29_out), 32'(0));
        check("arst_v7",    32'(v7_out), 32'(0));
        check("arst_ready", 32'(bus.cmd_ready), 32'(1));
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (2) tick();

        // max hold, en=0: 64 RUN cycles, done at cycle 65 after accept
        send(7'h3c, 2'b01, 1'b0, 4'd15);
        repeat (67) tick();

        // random traffic
        for (int i = 0; i < 400; i++) begin
            scramble_payload();
            bus.cmd_hold  = DWELL_W'($urandom_range(0, 3));
            bus.cmd_valid = ($urandom_range(0, 3) == 0);
            abort         = ($urandom_range(0, 15) == 0);
            tick();
        end
        bus.cmd_valid = 1'b0;
        abort         = 1'b0;
        repeat (25) tick();
        @(negedge clk);
        #1;
        check("done_count", 32'(dut_done_cnt), 32'(exp_done_cnt));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
